ahb_master: RTL
===============

# ahb_master

AHB-Lite single-transfer initiator for the verification and RTL library. Converts a simple valid/ready command port into AHB-Lite address and data phases and returns a one-cycle response pulse. Honours `hready` wait states and sits opposite the existing AHB slave model, driving the shared `haddr`/`htrans`/`hsize`/`hwrite`/`hwdata` bus. Single NONSEQ transfers only: no bursts, no BUSY, no SEQ.

## Interface
- `DW`, 32: data width; 32 or 64.
- `AW`, 32: address width.
- `hclk` input 1: bus clock; all logic on its rising edge.
- `hreset_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: command accepted on the edge where `cmd_valid && cmd_ready`.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input AW: byte address.
- `cmd_size` input 3: AHB `hsize` encoding; 0 = byte, 1 = half, 2 = word, 3 = dword.
- `cmd_wdata` input DW: write data.
- `rsp_valid` output 1: one-cycle pulse on transfer completion; no backpressure.
- `rsp_write` output 1: type of the completed transfer.
- `rsp_rdata` output DW: read data; holds its value until the next read completes.
- `haddr` output AW, `htrans` output 2, `hsize` output 3, `hwrite` output 1, `hwdata` output DW: AHB master outputs, all registered.
- `hrdata` input DW: AHB read data.
- `hready` input 1: AHB transfer-done or wait indication.

## Operation
- States:
  - IDLE: nothing outstanding.
  - ADDR: address phase on bus.
  - DATA: data phase only.
  - BOTH: data phase of A plus address phase of B. BOTH exists only with the pipeline macro.
- An edge "completes" when `hready`=1 at that edge.
- `cmd_ready`:
  - Without the macro: 1 only in IDLE.
  - With the macro: 1 in IDLE, or in ADDR/DATA/BOTH when `hready`=1. This path is combinational from `hready`.
- Accepting a command loads `haddr`, `hsize`, `hwrite`, and `htrans`=NONSEQ, and latches the write data internally.
- Address alignment: `haddr` = `cmd_addr` with its low `cmd_size` bits cleared. Example: size 2, addr 0x13 gives 0x10.
- ADDR, completing edge:
  - `hwdata` takes the latched write data.
  - Next state is DATA, or BOTH if a command is accepted on the same edge.
  - Without an accept, `htrans` goes to IDLE.
- DATA, completing edge:
  - `rsp_valid` pulses next cycle.
  - `rsp_rdata` captures `hrdata` when the transfer was a read.
  - Next state is IDLE, or ADDR if a command is accepted (pipeline mode only).
- BOTH, completing edge: A responds, B moves to its data phase. Next state is BOTH on accept, else DATA.
- `hready`=0 in any state: every AHB output holds.
- IDLE: `htrans`=IDLE (2'b00); `haddr`, `hsize`, `hwrite` and `hwdata` hold their last values.

## Timing
- Reset values: `htrans`=2'b00, `haddr`=0, `hsize`=0, `hwrite`=0, `hwdata`=0, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0. State is IDLE, so `cmd_ready`=1.
- Latency with zero wait states:
  - Accept at edge N.
  - Address phase completes at N+1.
  - Data phase completes at N+2.
  - `rsp_valid` is high in the cycle after N+2.
- Each wait cycle adds exactly one cycle.
- Reset asserted mid-transfer: the outstanding transfer is abandoned, no `rsp_valid` is produced, and all outputs go to their reset values immediately.

## Configuration
- Macro: `AHB_MASTER_PIPELINE_EN`.
- Defined:
  - The address phase of B overlaps the data phase of A.
  - Sustained throughput is 1 transfer/cycle with `hready`=1.
  - The BOTH state exists.
- Undefined:
  - At most one transfer is outstanding.
  - At least one IDLE cycle separates transfers.
  - Throughput is at most 1 transfer/3 cycles.
  - The BOTH state is absent.

## Test plan
- Write 0xDEADBEEF to 0x08, then read 0x08, against the AHB slave model with `hready`=1 -> the read gives `rsp_rdata`=0xDEADBEEF and `rsp_valid` 3 cycles after accept.
- Hold `hready`=0 for 2 cycles during the address phase of a write to 0x04 -> `haddr`, `hwrite` and `htrans`=NONSEQ stable; `rsp_valid` 5 cycles after accept.
- Read with size 1 at addr 0x13 -> `haddr`=0x12, `hsize`=3'b001.
- Macro defined: 4 back-to-back writes to 0x0/0x4/0x8/0xC with `cmd_valid` held high -> `htrans`=NONSEQ for 4 consecutive cycles and 4 consecutive `rsp_valid` pulses. Macro undefined: the same stimulus gives `htrans`=IDLE between transfers.
- Assert `hreset_n`=0 while in DATA on a read -> no `rsp_valid`, `htrans`=2'b00 immediately, `cmd_ready`=1 after release.
- `hready`=0 while in BOTH (macro defined) -> both phases hold; a single `hready` pulse yields exactly one response.

Source files
------------

// File: rtl/ahb_master.sv
// ahb_master: AHB-Lite single-transfer initiator.
//
// Turns a valid/ready command port into AHB-Lite address and data phases
// (single NONSEQ transfers only) and returns a one-cycle response pulse.
// hready wait states stretch whichever phase is on the bus.
//
// Build option: define AHB_MASTER_PIPELINE_EN to overlap the address phase
// of the next transfer with the data phase of the current one (BOTH state).
// Without it, at most one transfer is outstanding.
//
// Ports:
//   hclk, hreset_n     bus clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake; accept on cmd_valid && cmd_ready
//   cmd_write          1 = write, 0 = read
//   cmd_addr           byte address (aligned down to cmd_size on the bus)
//   cmd_size           hsize encoding (0 byte, 1 half, 2 word, 3 dword)
//   cmd_wdata          write data
//   rsp_valid          one-cycle completion pulse, no backpressure
//   rsp_write          type of the completed transfer
//   rsp_rdata          read data, held until the next read completes
//   haddr, htrans, hsize, hwrite, hwdata   registered AHB master outputs
//   hrdata, hready     AHB read data and transfer-done/wait indication
module ahb_master #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic          hclk,
  input  logic          hreset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic          rsp_write,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] haddr,
  output logic [1:0]    htrans,
  output logic [2:0]    hsize,
  output logic          hwrite,
  output logic [DW-1:0] hwdata,
  input  logic [DW-1:0] hrdata,
  input  logic          hready
);

  localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;
  localparam logic [AW-1:0] ALL_ONES      = '1;

`ifdef AHB_MASTER_PIPELINE_EN
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_BOTH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
`endif

  state_t        state;
  state_t        state_next;
  logic          accept;
  logic          addr_done;   // address phase on the bus completes this edge
  logic          data_done;   // data phase on the bus completes this edge
  logic [AW-1:0] aligned_addr;
  logic [DW-1:0] wdata_q;     // write data waiting for its data phase
  logic          data_write;  // direction of the transfer in its data phase

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    cmd_ready    = 1'b0;
    addr_done    = 1'b0;
    data_done    = 1'b0;
    aligned_addr = cmd_addr & (ALL_ONES << cmd_size);

    case (state)
      S_IDLE:  cmd_ready = 1'b1;
`ifdef AHB_MASTER_PIPELINE_EN
      S_ADDR,
      S_DATA,
      S_BOTH:  cmd_ready = hready;
`endif
      default: cmd_ready = 1'b0;
    endcase

    accept = cmd_valid && cmd_ready;

    case (state)
      S_IDLE: begin
        if (accept) state_next = S_ADDR;
      end
      S_ADDR: begin
        if (hready) begin
          addr_done = 1'b1;
`ifdef AHB_MASTER_PIPELINE_EN
          state_next = accept ? S_BOTH : S_DATA;
`else
          state_next = S_DATA;
`endif
        end
      end
      S_DATA: begin
        if (hready) begin
          data_done = 1'b1;
`ifdef AHB_MASTER_PIPELINE_EN
          state_next = accept ? S_ADDR : S_IDLE;
`else
          state_next = S_IDLE;
`endif
        end
      end
`ifdef AHB_MASTER_PIPELINE_EN
      S_BOTH: begin
        if (hready) begin
          addr_done  = 1'b1;
          data_done  = 1'b1;
          state_next = accept ? S_BOTH : S_DATA;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // The data-phase direction is taken from hwrite before a same-edge accept
  // overwrites it, so the completing transfer and the new one never mix.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      haddr      <= '0;
      htrans     <= HTRANS_IDLE;
      hsize      <= '0;
      hwrite     <= 1'b0;
      hwdata     <= '0;
      wdata_q    <= '0;
      data_write <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= data_done;
      if (data_done) begin
        rsp_write <= data_write;
        if (!data_write) rsp_rdata <= hrdata;
      end
      if (addr_done) begin
        hwdata     <= wdata_q;
        data_write <= hwrite;
      end
      if (accept) begin
        haddr   <= aligned_addr;
        hsize   <= cmd_size;
        hwrite  <= cmd_write;
        htrans  <= HTRANS_NONSEQ;
        wdata_q <= cmd_wdata;
      end else if (addr_done) begin
        htrans <= HTRANS_IDLE;
      end
    end
  end

endmodule
